// File: rtl/watch_time_set_ctrl.sv
// Watch timekeeping core: 100 Hz time base, hour/min/sec/cs counters and the
// RUN/SET_HOUR/SET_MIN/SET_SEC edit machine that feeds the FND controller.
module watch_time_set_ctrl #(
    parameter int CLK_FREQ    = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int INIT_HOUR   = 12,
    parameter int BLINK_TICKS = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_set,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_mode,
    output logic [23:0] o_time,
    output logic        o_mode,
    output logic [1:0]  o_edit,
    output logic        o_blink
);

    localparam int DIV_TC = CLK_FREQ / TICK_HZ - 1;
    localparam int DIV_W  = (DIV_TC < 2) ? 1 : $clog2(DIV_TC + 1);
    localparam int BLK_W  = (BLINK_TICKS < 2) ? 1 : $clog2(BLINK_TICKS);

    localparam logic [DIV_W-1:0] DIV_TC_V     = DIV_W'(DIV_TC);
    localparam logic [BLK_W-1:0] BLINK_LAST_V = BLK_W'(BLINK_TICKS - 1);
    localparam logic [4:0]       INIT_HOUR_V  = 5'(INIT_HOUR);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_SEC  = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [6:0]       r_cs;
    logic [5:0]       r_sec;
    logic [5:0]       r_min;
    logic [4:0]       r_hour;
    logic             r_user_mode;
    logic             r_mode;
    logic [1:0]       r_edit;
    logic             r_blink;
    logic [BLK_W-1:0] r_blink_cnt;

    logic       w_tick;
    logic       w_in_set;
    logic       w_leave_set;
    logic       w_run_tick;
    logic       w_adj_up;
    logic       w_adj_dn;
    logic       w_user_mode_nxt;
    logic [5:0] w_hour_step;
    logic [5:0] w_min_step;
    logic [5:0] w_sec_step;

    // Wrapping +/-1 on a field whose range is 0..max.
    function automatic logic [5:0] f_step(input logic [5:0] v,
                                          input logic [5:0] max,
                                          input logic       up);
        if (up) return (v == max) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? max : v - 6'd1;
    endfunction

    assign w_tick          = (r_div == DIV_TC_V);
    assign w_in_set        = (r_state != ST_RUN);
    assign w_leave_set     = btn_set && (r_state == ST_SET_SEC);
    assign w_run_tick      = w_tick && !w_in_set;
    // btn_set wins over up/down; up and down together cancel.
    assign w_adj_up        = w_in_set && !btn_set && btn_up && !btn_down;
    assign w_adj_dn        = w_in_set && !btn_set && btn_down && !btn_up;
    assign w_user_mode_nxt = r_user_mode ^ btn_mode;

    assign w_hour_step = f_step({1'b0, r_hour}, 6'd23, w_adj_up);
    assign w_min_step  = f_step(r_min, 6'd59, w_adj_up);
    assign w_sec_step  = f_step(r_sec, 6'd59, w_adj_up);

    // Time base; restarted on leaving edit so the first tick is a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
        end else if (w_leave_set || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs   <= '0;
            r_sec  <= '0;
            r_min  <= '0;
            r_hour <= INIT_HOUR_V;
        end else begin
            if (w_run_tick) begin
                if (r_cs == 7'd99) begin
                    r_cs <= '0;
                    if (r_sec == 6'd59) begin
                        r_sec <= '0;
                        if (r_min == 6'd59) begin
                            r_min  <= '0;
                            r_hour <= (r_hour == 5'd23) ? 5'd0 : r_hour + 5'd1;
                        end else begin
                            r_min <= r_min + 6'd1;
                        end
                    end else begin
                        r_sec <= r_sec + 6'd1;
                    end
                end else begin
                    r_cs <= r_cs + 7'd1;
                end
            end
            if (w_leave_set) begin
                r_cs <= '0;
            end
            if (w_adj_up || w_adj_dn) begin
                case (r_state)
                    ST_SET_HOUR: r_hour <= w_hour_step[4:0];
                    ST_SET_MIN:  r_min  <= w_min_step;
                    ST_SET_SEC:  r_sec  <= w_sec_step;
                    default:     ;
                endcase
            end
        end
    end

    // Edit FSM; o_edit and o_mode are registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_edit      <= 2'd0;
            r_mode      <= 1'b0;
            r_user_mode <= 1'b0;
        end else begin
            r_user_mode <= w_user_mode_nxt;
            case (r_state)
                ST_RUN: begin
                    if (btn_set) begin
                        r_state <= ST_SET_HOUR;
                        r_edit  <= 2'd1;
                        r_mode  <= 1'b1;
                    end else begin
                        r_mode  <= w_user_mode_nxt;
                    end
                end
                ST_SET_HOUR: begin
                    r_mode <= 1'b1;
                    if (btn_set) begin
                        r_state <= ST_SET_MIN;
                        r_edit  <= 2'd2;
                    end
                end
                ST_SET_MIN: begin
                    if (btn_set) begin
                        r_state <= ST_SET_SEC;
                        r_edit  <= 2'd3;
                        r_mode  <= 1'b0;
                    end else begin
                        r_mode  <= 1'b1;
                    end
                end
                ST_SET_SEC: begin
                    if (btn_set) begin
                        r_state <= ST_RUN;
                        r_edit  <= 2'd0;
                        r_mode  <= w_user_mode_nxt;
                    end else begin
                        r_mode  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_edit  <= 2'd0;
                    r_mode  <= w_user_mode_nxt;
                end
            endcase
        end
    end

    // Blink phase runs continuously across the SET states, cleared in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (!w_in_set || w_leave_set) begin
            r_blink     <= 1'b0;
            r_blink_cnt <= '0;
        end else if (w_tick) begin
            if (r_blink_cnt == BLINK_LAST_V) begin
                r_blink_cnt <= '0;
                r_blink     <= ~r_blink;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLK_W'(1);
            end
        end
    end

    assign o_time  = {r_hour, r_min, r_sec, r_cs};
    assign o_mode  = r_mode;
    assign o_edit  = r_edit;
    assign o_blink = r_blink;

endmodule

// File: tb/tb_watch_time_set_ctrl.sv
// Directed bench for watch_time_set_ctrl with a 10-clk tick (CLK_FREQ=1000, TICK_HZ=100).
module tb_watch_time_set_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_set, btn_up, btn_down, btn_mode;
    logic [23:0] o_time;
    logic        o_mode;
    logic [1:0]  o_edit;
    logic        o_blink;

    int n_total = 0;
    int n_bad   = 0;

    watch_time_set_ctrl #(
        .CLK_FREQ(1000), .TICK_HZ(100), .INIT_HOUR(12), .BLINK_TICKS(25)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down), .btn_mode(btn_mode),
        .o_time(o_time), .o_mode(o_mode), .o_edit(o_edit), .o_blink(o_blink)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] tw(input int h, input int m, input int s, input int c);
        logic [4:0] hh;
        logic [5:0] mm;
        logic [5:0] ss;
        logic [6:0] cc;
        hh = 5'(h); mm = 6'(m); ss = 6'(s); cc = 7'(c);
        return {hh, mm, ss, cc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic s, input logic u, input logic d, input logic m);
        btn_set = s; btn_up = u; btn_down = d; btn_mode = m;
        cyc(1);
        btn_set = 0; btn_up = 0; btn_down = 0; btn_mode = 0;
    endtask

    task automatic do_reset();
        rst = 1; btn_set = 0; btn_up = 0; btn_down = 0; btn_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        do_reset();
        check("rst_time", o_time, tw(12, 0, 0, 0));
        check("rst_mode", o_mode, 0);
        check("rst_edit", o_edit, 0);
        check("rst_blink", o_blink, 0);

        // Time base: tick lands on the 10th edge after release
        cyc(9);   check("cs_before_tick", o_time, tw(12, 0, 0, 0));
        cyc(1);   check("cs_first_tick", o_time, tw(12, 0, 0, 1));
        cyc(990); check("sec_carry", o_time, tw(12, 0, 1, 0));
        cyc(30);  check("cs_3", o_time, tw(12, 0, 1, 3));

        // Enter SET_HOUR, freeze, blink phase
        press(1, 0, 0, 0);
        check("sh_edit", o_edit, 1);
        check("sh_mode", o_mode, 1);
        check("sh_blink0", o_blink, 0);
        cyc(248); check("blink_pre", o_blink, 0);
        cyc(1);   check("blink_on", o_blink, 1);
        cyc(251); check("blink_off", o_blink, 0);
        check("frozen", o_time, tw(12, 0, 1, 3));

        for (int i = 0; i < 3; i++) press(0, 1, 0, 0);
        check("hour_15", o_time[23:19], 15);
        for (int i = 0; i < 9; i++) press(0, 1, 0, 0);
        check("hour_wrap_up", o_time[23:19], 0);
        press(0, 0, 1, 0);
        check("hour_wrap_dn", o_time[23:19], 23);
        press(1, 0, 0, 0); check("sm_edit", o_edit, 2); check("sm_mode", o_mode, 1);
        press(1, 0, 0, 0); check("ss_edit", o_edit, 3); check("ss_mode", o_mode, 0);
        check("cs_held", o_time, tw(23, 0, 1, 3));
        press(1, 0, 0, 0);
        check("run_edit", o_edit, 0);
        check("run_cs_clr", o_time, tw(23, 0, 1, 0));
        check("run_blink", o_blink, 0);
        cyc(9); check("div_clr_pre", o_time, tw(23, 0, 1, 0));
        cyc(1); check("div_clr_tick", o_time, tw(23, 0, 1, 1));

        // Build 23:59:59 through the set path
        press(1, 0, 0, 0);
        press(1, 0, 0, 0);
        press(0, 0, 1, 0); check("min_wrap_dn", o_time[18:13], 59);
        press(0, 1, 0, 0); check("min_wrap_up", o_time[18:13], 0);
        press(0, 0, 1, 0);
        press(0, 1, 1, 0); check("min_updn", o_time[18:13], 59);
        press(1, 1, 0, 0);
        check("set_up_edit", o_edit, 3);
        check("set_up_min", o_time[18:13], 59);
        press(0, 0, 1, 0); check("sec_dn", o_time[12:7], 0);
        press(0, 0, 1, 0); check("sec_wrap_dn", o_time[12:7], 59);
        press(1, 0, 0, 0); check("back_run", o_time, tw(23, 59, 59, 0));
        cyc(990); check("cs_99", o_time, tw(23, 59, 59, 99));
        cyc(9);   check("pre_wrap", o_time, tw(23, 59, 59, 99));
        cyc(1);
        check("day_wrap", o_time, 0);
        check("wrap_hour", o_time[23:19], 0);
        check("wrap_min", o_time[18:13], 0);
        check("wrap_sec", o_time[12:7], 0);
        check("wrap_cs", o_time[6:0], 0);

        // Display mode
        press(0, 0, 0, 1); check("mode_run", o_mode, 1);
        press(1, 0, 0, 0); check("mode_sh", o_mode, 1);
        press(1, 0, 0, 0); check("mode_sm", o_mode, 1);
        press(1, 0, 0, 0); check("mode_ss", o_mode, 0);
        press(1, 0, 0, 0); check("mode_ret", o_mode, 1); check("mode_ret_edit", o_edit, 0);
        press(0, 0, 0, 1); check("mode_tog_back", o_mode, 0);
        press(0, 0, 0, 1); check("mode_tog_again", o_mode, 1);

        // Async reset during an edit
        do_reset();
        check("rst2_mode", o_mode, 0);
        press(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) press(0, 1, 0, 0);
        check("pre_rst_hour", o_time[23:19], 15);
        check("pre_rst_edit", o_edit, 1);
        #3 rst = 1;
        #2;
        check("async_time", o_time, tw(12, 0, 0, 0));
        check("async_edit", o_edit, 0);
        check("async_mode", o_mode, 0);
        check("async_blink", o_blink, 0);
        #1 rst = 0;
        cyc(1);
        check("post_rst_time", o_time, tw(12, 0, 0, 0));
        check("post_rst_edit", o_edit, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
